// File: rtl/cache_bus_pkg.sv
// rtl/cache_bus_pkg.sv - shared types and tag constants for the cache bus arbiter
package cache_bus_pkg;

    localparam int TAG_WIDTH = 13;

    // tag layout: [1:0] op, [3:2] space, [5:4] stream, [12:6] reserved
    localparam logic [TAG_WIDTH-1:0] TAG_READ   = 13'h001;
    localparam logic [TAG_WIDTH-1:0] TAG_WRITE  = 13'h002;
    localparam logic [TAG_WIDTH-1:0] TAG_MEMORY = 13'h004;
    localparam logic [TAG_WIDTH-1:0] TAG_DATA   = 13'h010;
    localparam logic [TAG_WIDTH-1:0] TAG_INSN   = 13'h020;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        REQ_INSN = 1'b0,
        REQ_DATA = 1'b1
    } requester_e;

endpackage

// File: rtl/cache_bus_arbiter_rr_pick2.sv
// rtl/cache_bus_arbiter_rr_pick2.sv - two-way round-robin picker
// Purely combinational; the caller owns the last-grant register.
module rr_pick2
    import cache_bus_pkg::*;
(
    input  logic       req_insn,
    input  logic       req_data,
    input  requester_e last_grant,
    output logic       gnt_valid,
    output requester_e gnt_id
);

    always_comb begin
        gnt_valid = req_insn | req_data;
        gnt_id    = REQ_INSN;
        if (req_insn && req_data) begin
            gnt_id = (last_grant == REQ_INSN) ? REQ_DATA : REQ_INSN;
        end else if (req_data) begin
            gnt_id = REQ_DATA;
        end
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - shares one cache request/response bus between fetch and memory stages
// One transaction outstanding at a time; grants alternate round-robin on contention.
module cache_bus_arbiter
    import cache_bus_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int TAG_WIDTH  = cache_bus_pkg::TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  insnReqcycIn,
    input  logic [ADDR_WIDTH-1:0] insnReqIn,
    input  logic [TAG_WIDTH-1:0]  insnReqtagIn,
    output logic                  insnReqackOut,
    output logic                  insnRespcycOut,
    output logic [DATA_WIDTH-1:0] insnRespOut,
    input  logic                  insnRespackIn,
    input  logic                  dataReqcycIn,
    input  logic [ADDR_WIDTH-1:0] dataReqIn,
    input  logic [TAG_WIDTH-1:0]  dataReqtagIn,
    output logic                  dataReqackOut,
    output logic                  dataRespcycOut,
    output logic [DATA_WIDTH-1:0] dataRespOut,
    input  logic                  dataRespackIn,
    output logic                  reqcycOut,
    output logic [ADDR_WIDTH-1:0] reqOut,
    output logic [TAG_WIDTH-1:0]  reqtagOut,
    input  logic                  reqackIn,
    input  logic                  respcycIn,
    input  logic [DATA_WIDTH-1:0] respIn,
    output logic                  respackOut,
    output logic                  busyOut,
    output logic                  ownerOut
);

    state_e                state_q, state_d;
    requester_e            owner_q, owner_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TAG_WIDTH-1:0]  tag_q, tag_d;

    logic       gnt_valid;
    requester_e gnt_id;
    logic       own_respack;
    logic       own_reqcyc;
    logic       resp_phase;
    logic       is_data;

    // owner_q doubles as the last-grant pointer: outside a transaction it is the last winner
    rr_pick2 u_pick (
        .req_insn   (insnReqcycIn),
        .req_data   (dataReqcycIn),
        .last_grant (owner_q),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    assign is_data     = (owner_q == REQ_DATA);
    assign own_respack = is_data ? dataRespackIn : insnRespackIn;
    assign own_reqcyc  = is_data ? dataReqcycIn  : insnReqcycIn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_INSN;
            addr_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = REQ;
                    owner_d = gnt_id;
                    addr_d  = (gnt_id == REQ_DATA) ? dataReqIn    : insnReqIn;
                    tag_d   = (gnt_id == REQ_DATA) ? dataReqtagIn : insnReqtagIn;
                end
            end
            REQ: begin
                // an ack fused with the response can complete without visiting WAIT
                if (reqackIn) begin
                    state_d = (respcycIn && own_respack) ? IDLE : WAIT;
                end
            end
            WAIT: begin
                if (respcycIn && own_respack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        resp_phase     = (state_q == WAIT) || ((state_q == REQ) && reqackIn);
        reqcycOut      = (state_q == REQ);
        reqOut         = addr_q;
        reqtagOut      = tag_q;
        busyOut        = (state_q != IDLE);
        ownerOut       = owner_q;
        insnReqackOut  = (state_q == REQ) && reqackIn && !is_data;
        dataReqackOut  = (state_q == REQ) && reqackIn &&  is_data;
        insnRespcycOut = resp_phase && respcycIn && !is_data;
        dataRespcycOut = resp_phase && respcycIn &&  is_data;
        insnRespOut    = (resp_phase && !is_data) ? respIn : '0;
        dataRespOut    = (resp_phase &&  is_data) ? respIn : '0;
        respackOut     = resp_phase && respcycIn && own_respack;
    end

    // requesters must hold reqcyc until their reqack
    assert property (@(posedge clk) disable iff (reset)
        (state_q == REQ) |-> own_reqcyc);

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;
    import cache_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        insnReqcycIn, dataReqcycIn, insnRespackIn, dataRespackIn;
    logic [63:0] insnReqIn, dataReqIn, reqOut, respIn, insnRespOut, dataRespOut;
    logic [12:0] insnReqtagIn, dataReqtagIn, reqtagOut;
    logic        insnReqackOut, dataReqackOut, insnRespcycOut, dataRespcycOut;
    logic        reqcycOut, reqackIn, respcycIn, respackOut, busyOut, ownerOut;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_addr_q[$];
    logic [12:0] exp_tag_q[$];
    logic [63:0] exp_data_q[$];

    localparam logic [12:0] TI = TAG_READ | TAG_MEMORY | TAG_INSN;
    localparam logic [12:0] TD = TAG_WRITE | TAG_MEMORY | TAG_DATA;

    cache_bus_arbiter dut (
        .clk(clk), .reset(reset),
        .insnReqcycIn(insnReqcycIn), .insnReqIn(insnReqIn), .insnReqtagIn(insnReqtagIn),
        .insnReqackOut(insnReqackOut), .insnRespcycOut(insnRespcycOut),
        .insnRespOut(insnRespOut), .insnRespackIn(insnRespackIn),
        .dataReqcycIn(dataReqcycIn), .dataReqIn(dataReqIn), .dataReqtagIn(dataReqtagIn),
        .dataReqackOut(dataReqackOut), .dataRespcycOut(dataRespcycOut),
        .dataRespOut(dataRespOut), .dataRespackIn(dataRespackIn),
        .reqcycOut(reqcycOut), .reqOut(reqOut), .reqtagOut(reqtagOut), .reqackIn(reqackIn),
        .respcycIn(respcycIn), .respIn(respIn), .respackOut(respackOut),
        .busyOut(busyOut), .ownerOut(ownerOut)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        insnReqcycIn = 0; insnReqIn = '0; insnReqtagIn = '0; insnRespackIn = 0;
        dataReqcycIn = 0; dataReqIn = '0; dataReqtagIn = '0; dataRespackIn = 0;
        reqackIn = 0; respcycIn = 0; respIn = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        @(negedge clk); #1;
        checks++;
        if ({reqcycOut, respackOut, busyOut, ownerOut, insnReqackOut, dataReqackOut,
             insnRespcycOut, dataRespcycOut} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {reqcycOut, respackOut,
                     busyOut, ownerOut, insnReqackOut, dataReqackOut, insnRespcycOut, dataRespcycOut});
        end
        checks++;
        if (reqOut !== 64'h0 || reqtagOut !== 13'h0 || insnRespOut !== 64'h0 || dataRespOut !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got req=%h tag=%h ir=%h dr=%h expected all 0",
                     reqOut, reqtagOut, insnRespOut, dataRespOut);
        end
        @(negedge clk); reset = 0;
    endtask

    task automatic test_single_insn();
        logic [63:0] ea, ed;
        logic [12:0] et;
        exp_addr_q.push_back(64'h1000); exp_tag_q.push_back(TI);
        @(negedge clk);
        insnReqcycIn = 1; insnReqIn = 64'h1000; insnReqtagIn = TI;
        #1; checks++;
        if (reqcycOut !== 1'b0) begin errors++; $display("FAIL single_early: reqcyc got %b expected 0", reqcycOut); end
        @(negedge clk); #1;
        ea = exp_addr_q.pop_front(); et = exp_tag_q.pop_front();
        checks++;
        if (reqcycOut !== 1'b1 || reqOut !== ea || reqtagOut !== et || ownerOut !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: cyc=%b addr=%h tag=%h own=%b expected 1 %h %h 0",
                     reqcycOut, reqOut, reqtagOut, ownerOut, ea, et);
        end
        @(negedge clk);
        @(negedge clk); reqackIn = 1; #1;
        checks++;
        if (insnReqackOut !== 1'b1 || dataReqackOut !== 1'b0) begin
            errors++;
            $display("FAIL single_ack: insn=%b data=%b expected 1 0", insnReqackOut, dataReqackOut);
        end
        @(negedge clk); reqackIn = 0; insnReqcycIn = 0; #1;
        checks++;
        if (reqcycOut !== 1'b0 || busyOut !== 1'b1) begin
            errors++;
            $display("FAIL single_turnaround: cyc=%b busy=%b expected 0 1", reqcycOut, busyOut);
        end
        @(negedge clk);
        @(negedge clk);
        respcycIn = 1; respIn = 64'hDEADBEEF; insnRespackIn = 1; exp_data_q.push_back(64'hDEADBEEF);
        #1; ed = exp_data_q.pop_front();
        checks++;
        if (insnRespcycOut !== 1'b1 || insnRespOut !== ed || respackOut !== 1'b1) begin
            errors++;
            $display("FAIL single_resp: cyc=%b data=%h ack=%b expected 1 %h 1", insnRespcycOut, insnRespOut, respackOut, ed);
        end
        checks++;
        if (dataRespcycOut !== 1'b0 || dataRespOut !== 64'h0) begin
            errors++;
            $display("FAIL single_other: cyc=%b data=%h expected 0 0", dataRespcycOut, dataRespOut);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (busyOut !== 1'b0) begin errors++; $display("FAIL single_done: busy got %b expected 0", busyOut); end
    endtask

    task automatic test_contention();
        logic [63:0] ea, ed;
        logic [12:0] et;
        idle_inputs(); reset = 1;
        insnReqcycIn = 1; insnReqIn = 64'h2000; insnReqtagIn = TI;
        dataReqcycIn = 1; dataReqIn = 64'h3000; dataReqtagIn = TD;
        exp_addr_q.push_back(64'h3000); exp_tag_q.push_back(TD);
        exp_addr_q.push_back(64'h2000); exp_tag_q.push_back(TI);
        exp_addr_q.push_back(64'h3008); exp_tag_q.push_back(TD);
        @(negedge clk); reset = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            reqackIn = 1;
            respcycIn = (n != 0); respIn = 64'h1111 * (n + 1);
            insnRespackIn = (n == 1); dataRespackIn = (n == 2);
            #1;
            ea = exp_addr_q.pop_front(); et = exp_tag_q.pop_front();
            checks++;
            if (reqcycOut !== 1'b1 || reqOut !== ea || reqtagOut !== et || ownerOut !== (n != 1)) begin
                errors++;
                $display("FAIL contention_grant%0d: cyc=%b addr=%h tag=%h own=%b expected 1 %h %h %b",
                         n, reqcycOut, reqOut, reqtagOut, ownerOut, ea, et, (n != 1));
            end
            if (n == 0) begin
                @(negedge clk);
                reqackIn = 0; dataReqIn = 64'h3008;
                respcycIn = 1; respIn = 64'h5A5A; dataRespackIn = 1; exp_data_q.push_back(64'h5A5A);
                #1; ed = exp_data_q.pop_front();
                checks++;
                if (dataRespcycOut !== 1'b1 || dataRespOut !== ed || insnRespcycOut !== 1'b0) begin
                    errors++;
                    $display("FAIL contention_resp: cyc=%b data=%h icyc=%b expected 1 %h 0",
                             dataRespcycOut, dataRespOut, insnRespcycOut, ed);
                end
            end
            @(negedge clk);
            reqackIn = 0; respcycIn = 0; insnRespackIn = 0; dataRespackIn = 0;
            if (n == 1) insnReqcycIn = 0;
            if (n == 2) dataReqcycIn = 0;
            #1; checks++;
            if (busyOut !== 1'b0 || reqcycOut !== 1'b0) begin
                errors++;
                $display("FAIL contention_bubble%0d: busy=%b cyc=%b expected 0 0", n, busyOut, reqcycOut);
            end
        end
        idle_inputs();
    endtask

    task automatic test_fused();
        @(negedge clk);
        dataReqcycIn = 1; dataReqIn = 64'h4400; dataReqtagIn = TD;
        @(negedge clk);
        reqackIn = 1; respcycIn = 1; respIn = 64'hF00D; dataRespackIn = 1;
        #1; checks++;
        if (dataReqackOut !== 1'b1 || dataRespcycOut !== 1'b1 || dataRespOut !== 64'hF00D || respackOut !== 1'b1) begin
            errors++;
            $display("FAIL fused_cycle: ack=%b cyc=%b data=%h rack=%b expected 1 1 f00d 1",
                     dataReqackOut, dataRespcycOut, dataRespOut, respackOut);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (busyOut !== 1'b0 || reqcycOut !== 1'b0) begin
            errors++;
            $display("FAIL fused_idle: busy=%b cyc=%b expected 0 0", busyOut, reqcycOut);
        end
    endtask

    task automatic test_late_respack();
        @(negedge clk);
        insnReqcycIn = 1; insnReqIn = 64'h4000; insnReqtagIn = TI;
        @(negedge clk); reqackIn = 1;
        @(negedge clk); reqackIn = 0; insnReqcycIn = 0;
        respcycIn = 1; respIn = 64'h55;
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            insnRespackIn = (i == 2);
            #1; checks++;
            if (respackOut !== (i == 2) || insnRespcycOut !== 1'b1 || busyOut !== 1'b1) begin
                errors++;
                $display("FAIL late_respack%0d: rack=%b cyc=%b busy=%b expected %b 1 1",
                         i, respackOut, insnRespcycOut, busyOut, (i == 2));
            end
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (busyOut !== 1'b0) begin errors++; $display("FAIL late_done: busy got %b expected 0", busyOut); end
    endtask

    task automatic test_isolation();
        @(negedge clk);
        dataReqcycIn = 1; dataReqIn = 64'h5000; dataReqtagIn = TD;
        @(negedge clk); reqackIn = 1;
        @(negedge clk); reqackIn = 0; dataReqcycIn = 0;
        respcycIn = 1; respIn = 64'h66; insnRespackIn = 1;
        #1; checks++;
        if (respackOut !== 1'b0 || insnRespcycOut !== 1'b0 || insnRespOut !== 64'h0 || dataRespcycOut !== 1'b1) begin
            errors++;
            $display("FAIL isolation_wait: rack=%b icyc=%b idata=%h dcyc=%b expected 0 0 0 1",
                     respackOut, insnRespcycOut, insnRespOut, dataRespcycOut);
        end
        @(negedge clk); #1;
        checks++;
        if (busyOut !== 1'b1) begin errors++; $display("FAIL isolation_hold: busy got %b expected 1", busyOut); end
        dataRespackIn = 1; #1;
        checks++;
        if (respackOut !== 1'b1 || insnRespOut !== 64'h0 || dataRespOut !== 64'h66) begin
            errors++;
            $display("FAIL isolation_done: rack=%b idata=%h ddata=%h expected 1 0 66", respackOut, insnRespOut, dataRespOut);
        end
        @(negedge clk); idle_inputs(); #1;
        checks++;
        if (busyOut !== 1'b0) begin errors++; $display("FAIL isolation_idle: busy got %b expected 0", busyOut); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        insnReqcycIn = 1; insnReqIn = 64'h6000; insnReqtagIn = TI;
        @(negedge clk); reqackIn = 1;
        @(negedge clk); reqackIn = 0; insnReqcycIn = 0; respcycIn = 1; respIn = 64'h77;
        #1; checks++;
        if (insnRespcycOut !== 1'b1) begin errors++; $display("FAIL resetmid_pre: cyc got %b expected 1", insnRespcycOut); end
        #2 reset = 1;
        #1; checks++;
        if ({reqcycOut, respackOut, busyOut, ownerOut, insnReqackOut, insnRespcycOut, dataRespcycOut} !== 7'h0
            || insnRespOut !== 64'h0 || reqOut !== 64'h0) begin
            errors++;
            $display("FAIL resetmid_async: ctrl=%b idata=%h req=%h expected 0",
                     {reqcycOut, respackOut, busyOut, ownerOut, insnReqackOut, insnRespcycOut, dataRespcycOut},
                     insnRespOut, reqOut);
        end
        @(negedge clk);
        idle_inputs(); dataReqcycIn = 1; dataReqIn = 64'h7000; dataReqtagIn = TD; reset = 0;
        @(negedge clk); reqackIn = 1; respcycIn = 1; respIn = 64'h88; dataRespackIn = 1;
        #1; checks++;
        if (reqcycOut !== 1'b1 || ownerOut !== 1'b1 || reqOut !== 64'h7000 || dataRespOut !== 64'h88) begin
            errors++;
            $display("FAIL resetmid_regrant: cyc=%b own=%b addr=%h data=%h expected 1 1 7000 88",
                     reqcycOut, ownerOut, reqOut, dataRespOut);
        end
        @(negedge clk); idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_insn();
        test_contention();
        test_fused();
        test_late_respack();
        test_isolation();
        test_reset_mid();
        checks++;
        if (exp_addr_q.size() != 0 || exp_data_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: addr=%0d data=%0d left expected 0", exp_addr_q.size(), exp_data_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
